l1mtx_input_hold: RTL and testbench
===================================

# l1mtx_input_hold

Master-side input stage for the L1MTX AHB bus matrix: one instance per master (slave) port. It accepts the master's address phase and forwards it to the address decoder and output-stage arbiters. When the target output arbiter has not granted this port, it captures the transfer in a holding register and stalls the master. During the data phase it relays the output stage's HREADYOUT/HRESP back to the master.

## Interface
- ADDR_WIDTH, 32, address width.

- HCLK  in  1  AHB system clock.
- HRESETn  in  1  reset; synchronous, active-low.
- HSELS  in  1  port select from the master.
- HADDRS  in  ADDR_WIDTH  address.
- HTRANSS  in  2  transfer type.
- HWRITES  in  1  write.
- HSIZES  in  3  size.
- HBURSTS  in  3  burst.
- HPROTS  in  4  protection.
- HMASTLOCKS  in  1  lock.
- HREADYS  in  1  bus HREADY seen by the master.
- HREADYOUTS  out  1  ready to the master.
- HRESPS  out  2  response to the master.
- active_trans  in  1  an output arbiter selects this port and its HREADYM=1, so the presented address is taken this cycle.
- readyout_m  in  1  HREADYOUT of the output stage owning this port's data phase.
- resp_m  in  2  HRESP of that output stage.
- sel_o, addr_o, trans_o, write_o, size_o, burst_o, prot_o, mastlock_o  out  widths as inputs  address phase presented to decode/arbiters.
- trans_valid_o  out  1  a valid transfer is being requested (live or held).

## Operation
- new_req = HSELS & HTRANSS[1] & HREADYS. NONSEQ and SEQ count; IDLE and BUSY do not.
- Holding register: captures all address-phase inputs on new_req & ~active_trans. It is the only way to set pend. pend clears on active_trans & pend.
- Output mux:
  - pend=1: *_o driven from the holding register, with trans_o = held HTRANS.
  - pend=0: *_o driven from the live inputs.
  - trans_valid_o = pend | new_req.
  - sel_o = pend | HSELS.
- FSM states IDLE, PEND, DATA; next state is evaluated every cycle.
  - IDLE: HREADYOUTS=1, HRESPS=OKAY.
    - new_req & active_trans -> DATA.
    - new_req & ~active_trans -> PEND (capture).
    - otherwise stay.
  - PEND: HREADYOUTS=0, HRESPS=OKAY.
    - active_trans -> DATA.
    - otherwise stay. Master inputs are ignored; the holding register is not overwritten.
  - DATA: HREADYOUTS=readyout_m, HRESPS=resp_m.
    - readyout_m=0: stay.
    - readyout_m=1 with new_req: -> DATA if active_trans, else -> PEND (capture).
    - readyout_m=1 without new_req: -> IDLE.
- ERROR responses are relayed verbatim in both cycles (first cycle readyout_m=0, second =1). If the master issues IDLE in the second cycle, there is no new_req and the state returns to IDLE.
- The locked sequence is not interpreted here. mastlock_o follows the live or held value; lock holding is done by the output arbiters.

## Timing
- Reset (HRESETn=0 at a rising HCLK edge): state=IDLE, pend=0, holding register=0, HREADYOUTS=1, HRESPS=OKAY. Reset mid-PEND or mid-DATA discards the transfer at that edge.
- Zero-latency forward: a live granted request reaches *_o combinationally in the same cycle.
- A held request is presented from the cycle after capture and stays until the cycle active_trans=1. The master sees HREADYOUTS=1 in the cycle after that, at the earliest when readyout_m=1.
- HREADYOUTS and HRESPS are combinational from state and readyout_m/resp_m. They are never X after reset.
- Simultaneous new_req and active_trans in IDLE or DATA does not capture. active_trans in PEND takes priority over master inputs.

## Test plan
- Granted single write: IDLE, NONSEQ 0x2000_0000 with active_trans=1 -> addr_o=0x2000_0000 in the same cycle, trans_valid_o=1, no capture; next cycle DATA, HREADYOUTS follows readyout_m.
- Stall and hold: NONSEQ 0x1000_0010, active_trans=0 for 3 cycles with live inputs changed to IDLE -> addr_o=0x1000_0010 and trans_o=NONSEQ held, HREADYOUTS=0 for 3 cycles; active_trans=1 -> DATA next cycle.
- Back-to-back: in DATA with readyout_m=1, SEQ 0x..14 and active_trans=0 -> PEND with held SEQ 0x..14; DATA with readyout_m=1, no new_req -> IDLE, HREADYOUTS=1.
- Error relay: DATA, resp_m=ERROR with readyout_m=0 then 1, master IDLE -> HRESPS=ERROR both cycles, HREADYOUTS=0 then 1, then IDLE/OKAY.
- Reset mid-PEND: HRESETn=0 for one edge -> pend=0, trans_valid_o=0 (live IDLE), HREADYOUTS=1, HRESPS=OKAY; an asynchronous HRESETn pulse between edges has no effect.
- BUSY/HSELS=0/HREADYS=0 with HTRANSS=NONSEQ -> no new_req, no capture, trans_valid_o=0.

Source files
------------

// File: rtl/l1mtx_input_hold_if.sv
// Bundle of the master-side AHB address/response signals and the matrix-side
// decode/arbiter hooks seen by one L1MTX input stage.
interface l1mtx_input_hold_if #(
  parameter int ADDR_WIDTH = 32
);
  // AHB master port
  logic                  HSELS;
  logic [ADDR_WIDTH-1:0] HADDRS;
  logic [1:0]            HTRANSS;
  logic                  HWRITES;
  logic [2:0]            HSIZES;
  logic [2:0]            HBURSTS;
  logic [3:0]            HPROTS;
  logic                  HMASTLOCKS;
  logic                  HREADYS;
  logic                  HREADYOUTS;
  logic [1:0]            HRESPS;

  // Output-stage feedback
  logic                  active_trans;
  logic                  readyout_m;
  logic [1:0]            resp_m;

  // Address phase toward decoder and arbiters
  logic                  sel_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [1:0]            trans_o;
  logic                  write_o;
  logic [2:0]            size_o;
  logic [2:0]            burst_o;
  logic [3:0]            prot_o;
  logic                  mastlock_o;
  logic                  trans_valid_o;

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
           HREADYS, active_trans, readyout_m, resp_m,
    output HREADYOUTS, HRESPS, sel_o, addr_o, trans_o, write_o, size_o, burst_o,
           prot_o, mastlock_o, trans_valid_o
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
           HREADYS, active_trans, readyout_m, resp_m,
    input  HREADYOUTS, HRESPS, sel_o, addr_o, trans_o, write_o, size_o, burst_o,
           prot_o, mastlock_o, trans_valid_o
  );
endinterface

// File: rtl/l1mtx_input_hold.sv
// L1MTX master-side input stage: forwards or holds the address phase until an
// output arbiter takes it, and relays the owning output stage's response.
module l1mtx_input_hold #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  l1mtx_input_hold_if.slave  bus
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            trans;
    logic                  write;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic [3:0]            prot;
    logic                  mastlock;
  } aphase_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  state_e  state_q, state_d;
  aphase_t hold_q,  hold_d;
  aphase_t live;
  logic    new_req;
  logic    pend;

  assign live = '{
    addr:     bus.HADDRS,
    trans:    bus.HTRANSS,
    write:    bus.HWRITES,
    size:     bus.HSIZES,
    burst:    bus.HBURSTS,
    prot:     bus.HPROTS,
    mastlock: bus.HMASTLOCKS
  };

  // Only NONSEQ/SEQ on a selected, ready bus start a transfer.
  assign new_req = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;

  // The pending flag is exactly the PEND state: capture is the only way in,
  // a grant is the only way out.
  assign pend = (state_q == ST_PEND);

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        if (new_req) state_d = bus.active_trans ? ST_DATA : ST_PEND;
      end
      ST_PEND: begin
        if (bus.active_trans) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bus.readyout_m) begin
          if (new_req) state_d = bus.active_trans ? ST_DATA : ST_PEND;
          else         state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Capture only on entry to PEND; while pending the master is stalled and
    // whatever it drives must not disturb the held transfer.
    if (state_q != ST_PEND && state_d == ST_PEND) hold_d = live;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the holding register is reset along with the FSM so that the
  // presented address phase is never X after reset, even though it is only
  // observed while pending.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    bus.HREADYOUTS = 1'b1;
    bus.HRESPS     = RESP_OKAY;
    unique case (state_q)
      ST_PEND: bus.HREADYOUTS = 1'b0;
      ST_DATA: begin
        bus.HREADYOUTS = bus.readyout_m;
        bus.HRESPS     = bus.resp_m;
      end
      default: ;
    endcase
  end

  assign bus.addr_o        = pend ? hold_q.addr     : live.addr;
  assign bus.trans_o       = pend ? hold_q.trans    : live.trans;
  assign bus.write_o       = pend ? hold_q.write    : live.write;
  assign bus.size_o        = pend ? hold_q.size     : live.size;
  assign bus.burst_o       = pend ? hold_q.burst    : live.burst;
  assign bus.prot_o        = pend ? hold_q.prot     : live.prot;
  assign bus.mastlock_o    = pend ? hold_q.mastlock : live.mastlock;
  assign bus.sel_o         = pend | bus.HSELS;
  assign bus.trans_valid_o = pend | new_req;

endmodule

// File: tb/tb_l1mtx_input_hold.sv
// Directed and random bench for l1mtx_input_hold against a transaction-level
// model of the stall/hold behaviour.
module tb_l1mtx_input_hold;

  localparam int AW = 32;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [1:0] R_OKAY = 2'b00, R_ERR = 2'b01;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;

  l1mtx_input_hold_if #(.ADDR_WIDTH(AW)) bus ();

  l1mtx_input_hold #(.ADDR_WIDTH(AW)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: is the master stalled waiting for a grant, and is a granted
  // transfer's data phase outstanding?
  bit          m_stalled;
  bit          m_data_open;
  logic [31:0] h_addr;
  logic [1:0]  h_trans;
  logic        h_write, h_lock;
  logic [2:0]  h_size, h_burst;
  logic [3:0]  h_prot;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit live_req();
    return bus.HSELS && bus.HTRANSS[1] && bus.HREADYS;
  endfunction

  task automatic model_clear();
    m_stalled   = 0;
    m_data_open = 0;
    h_addr = '0; h_trans = '0; h_write = 0; h_lock = 0;
    h_size = '0; h_burst = '0; h_prot = '0;
  endtask

  task automatic check_outputs();
    bit nr;
    nr = live_req();
    check("hreadyouts", bus.HREADYOUTS, m_stalled ? 1'b0 : (m_data_open ? bus.readyout_m : 1'b1));
    check("hresps", bus.HRESPS, m_data_open ? bus.resp_m : R_OKAY);
    check("trans_valid_o", bus.trans_valid_o, m_stalled | nr);
    check("sel_o", bus.sel_o, m_stalled | bus.HSELS);
    check("addr_o", bus.addr_o, m_stalled ? h_addr : bus.HADDRS);
    check("trans_o", bus.trans_o, m_stalled ? h_trans : bus.HTRANSS);
    check("write_o", bus.write_o, m_stalled ? h_write : bus.HWRITES);
    check("size_o", bus.size_o, m_stalled ? h_size : bus.HSIZES);
    check("burst_o", bus.burst_o, m_stalled ? h_burst : bus.HBURSTS);
    check("prot_o", bus.prot_o, m_stalled ? h_prot : bus.HPROTS);
    check("mastlock_o", bus.mastlock_o, m_stalled ? h_lock : bus.HMASTLOCKS);
  endtask

  // Advance the model by one clock edge using the inputs in force at the edge.
  task automatic model_edge();
    bit nr;
    nr = live_req();
    if (!HRESETn) begin
      model_clear();
    end else if (m_stalled) begin
      if (bus.active_trans) begin
        m_stalled   = 0;
        m_data_open = 1;
      end
    end else if (!m_data_open || bus.readyout_m) begin
      if (!nr) begin
        m_data_open = 0;
      end else if (bus.active_trans) begin
        m_data_open = 1;
      end else begin
        m_data_open = 0;
        m_stalled   = 1;
        h_addr = bus.HADDRS; h_trans = bus.HTRANSS; h_write = bus.HWRITES;
        h_size = bus.HSIZES; h_burst = bus.HBURSTS; h_prot = bus.HPROTS;
        h_lock = bus.HMASTLOCKS;
      end
    end
  endtask

  // Inputs are driven just after the falling edge; outputs are checked
  // mid-low-phase, then the model follows the rising edge.
  task automatic step();
    #1;
    check_outputs();
    @(posedge HCLK);
    model_edge();
    @(negedge HCLK);
  endtask

  task automatic set_master(input logic sel, input logic [1:0] trans, input logic [31:0] addr, input logic wr);
    bus.HSELS      = sel;
    bus.HTRANSS    = trans;
    bus.HADDRS     = addr;
    bus.HWRITES    = wr;
    bus.HSIZES     = 3'($urandom_range(0, 2));
    bus.HBURSTS    = 3'($urandom_range(0, 7));
    bus.HPROTS     = 4'($urandom);
    bus.HMASTLOCKS = 1'($urandom);
    bus.HREADYS    = 1'b1;
  endtask

  initial begin
    set_master(1'b0, T_IDLE, 32'h0, 1'b0);
    bus.active_trans = 1'b0;
    bus.readyout_m   = 1'b1;
    bus.resp_m       = R_OKAY;
    HRESETn          = 1'b0;
    @(posedge HCLK);
    @(posedge HCLK);
    model_clear();
    @(negedge HCLK);

    // Reset state
    #1;
    check("reset_hreadyouts", bus.HREADYOUTS, 1'b1);
    check("reset_hresps", bus.HRESPS, R_OKAY);
    check("reset_trans_valid", bus.trans_valid_o, 1'b0);
    step();
    HRESETn = 1'b1;

    // Granted single write: forwarded in the same cycle
    set_master(1'b1, T_NSEQ, 32'h2000_0000, 1'b1);
    bus.active_trans = 1'b1;
    #1;
    check("grant_addr", bus.addr_o, 32'h2000_0000);
    check("grant_valid", bus.trans_valid_o, 1'b1);
    step();
    set_master(1'b1, T_IDLE, 32'h0, 1'b0);
    bus.active_trans = 1'b0;
    bus.readyout_m   = 1'b0;
    #1;
    check("data_wait_ready", bus.HREADYOUTS, 1'b0);
    step();
    bus.readyout_m = 1'b1;
    step();

    // Stall and hold for three cycles with the master gone IDLE
    set_master(1'b1, T_NSEQ, 32'h1000_0010, 1'b0);
    step();
    set_master(1'b1, T_IDLE, 32'hDEAD_BEE0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_addr", bus.addr_o, 32'h1000_0010);
      check("hold_trans", bus.trans_o, T_NSEQ);
      check("hold_ready", bus.HREADYOUTS, 1'b0);
      step();
    end
    bus.active_trans = 1'b1;
    step();
    bus.active_trans = 1'b0;

    // Back-to-back: SEQ in the final data cycle without a grant is held
    set_master(1'b1, T_SEQ, 32'h1000_0014, 1'b0);
    bus.readyout_m = 1'b1;
    step();
    set_master(1'b1, T_IDLE, 32'h0, 1'b0);
    #1;
    check("b2b_addr", bus.addr_o, 32'h1000_0014);
    check("b2b_trans", bus.trans_o, T_SEQ);
    step();
    bus.active_trans = 1'b1;
    step();
    bus.active_trans = 1'b0;
    step();
    #1;
    check("b2b_idle_ready", bus.HREADYOUTS, 1'b1);
    step();

    // Two-cycle ERROR relay, master goes IDLE in the second cycle
    set_master(1'b1, T_NSEQ, 32'h4000_0100, 1'b1);
    bus.active_trans = 1'b1;
    step();
    set_master(1'b1, T_IDLE, 32'h0, 1'b0);
    bus.active_trans = 1'b0;
    bus.readyout_m   = 1'b0;
    bus.resp_m       = R_ERR;
    #1;
    check("err1_resp", bus.HRESPS, R_ERR);
    check("err1_ready", bus.HREADYOUTS, 1'b0);
    step();
    bus.readyout_m = 1'b1;
    #1;
    check("err2_resp", bus.HRESPS, R_ERR);
    check("err2_ready", bus.HREADYOUTS, 1'b1);
    step();
    #1;
    check("err_after_resp", bus.HRESPS, R_OKAY);
    check("err_after_ready", bus.HREADYOUTS, 1'b1);
    step();
    bus.resp_m = R_OKAY;

    // Reset mid-PEND; a pulse between edges must not count
    set_master(1'b1, T_NSEQ, 32'h3000_0000, 1'b1);
    step();
    set_master(1'b1, T_IDLE, 32'h0, 1'b0);
    HRESETn = 1'b0;
    #2;
    HRESETn = 1'b1;
    check("async_pulse_ready", bus.HREADYOUTS, 1'b0);
    step();
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    #1;
    check("rst_pend_valid", bus.trans_valid_o, 1'b0);
    check("rst_pend_ready", bus.HREADYOUTS, 1'b1);
    check("rst_pend_resp", bus.HRESPS, R_OKAY);
    step();

    // Non-requests: BUSY, deselected, HREADYS low
    for (int k = 0; k < 3; k++) begin
      set_master(k != 1, (k == 0) ? T_BUSY : T_NSEQ, 32'h5000_0000 + 32'(k * 4), 1'b0);
      if (k == 2) bus.HREADYS = 1'b0;
      #1;
      check("noreq_valid", bus.trans_valid_o, 1'b0);
      step();
      set_master(1'b0, T_IDLE, 32'h0, 1'b0);
      #1;
      check("noreq_no_capture", bus.HREADYOUTS, 1'b1);
      step();
    end

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      set_master($urandom_range(0, 7) != 0, 2'($urandom), $urandom & 32'hFFFF_FFFC, 1'($urandom));
      bus.HREADYS      = $urandom_range(0, 5) != 0;
      bus.active_trans = $urandom_range(0, 2) == 0;
      bus.readyout_m   = $urandom_range(0, 3) != 0;
      bus.resp_m       = ($urandom_range(0, 7) == 0) ? R_ERR : R_OKAY;
      HRESETn          = $urandom_range(0, 49) != 0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
